muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the two long-latency ALU operations, DIV (aluOp 3'b101) and MULT (aluOp 3'b111).
- Accepts an operation from the control path, iterates one bit per cycle, then writes results to the HI/LO registers.
- Holds busy so the datapath can stall while it runs.
- Sits beside the single-cycle ALU and is fed by the same ALU-control aluOp field and operand buses.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/muldiv_step.sv | 45 ++++
 rtl/muldiv_sequencer.sv | 138 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU opcode constants and the mul/div sequencer state
//                type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  // ALU operation codes shared by the ALU-control decoder and the sequencer
  localparam logic [2:0] ALUOP_AND  = 3'b000;
  localparam logic [2:0] ALUOP_OR   = 3'b001;
  localparam logic [2:0] ALUOP_ADD  = 3'b010;
  localparam logic [2:0] ALUOP_SUB  = 3'b011;
  localparam logic [2:0] ALUOP_SLT  = 3'b100;
  localparam logic [2:0] ALUOP_DIV  = 3'b101;
  localparam logic [2:0] ALUOP_NOP  = 3'b110;
  localparam logic [2:0] ALUOP_MULT = 3'b111;

  // Multi-cycle sequencer states
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
// ============================================================================
//  Module      : muldiv_step
//  Description : One iteration of unsigned shift-add multiply or restoring
//                divide on a 2*WIDTH working register.
//                MUL: work = {partial product, remaining multiplier bits}
//                DIV: work = {partial remainder, dividend/quotient bits}
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   work_in,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   work_out
);

  logic [WIDTH-1:0] upper;
  logic [WIDTH-1:0] lower;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;

  // Single multiply or divide step; the carry/borrow bit is kept in WIDTH+1
  always_comb begin
    upper     = work_in[2*WIDTH-1:WIDTH];
    lower     = work_in[WIDTH-1:0];
    mul_sum   = {1'b0, upper} + (lower[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    div_shift = {upper, lower[WIDTH-1]};
    div_trial = div_shift - {1'b0, operand};
    work_out  = {mul_sum, lower[WIDTH-1:1]};
    if (is_div) begin
      if (!div_trial[WIDTH]) begin
        work_out = {div_trial[WIDTH-1:0], lower[WIDTH-2:0], 1'b1};
      end else begin
        work_out = {div_shift[WIDTH-1:0], lower[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Multi-cycle unsigned MULT/DIV sequencer writing HI/LO, with
//                busy for datapath stall, flush abort and divide-by-zero flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       aluOp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] step_out;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (state_q == MD_DIV),
    .work_in  (work_q),
    .operand  (opnd_q),
    .work_out (step_out)
  );

  // Next-state, iteration and HI/LO write logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        cnt_d = '0;
        // flush blocks acceptance of a same-cycle start
        if (start && !flush) begin
          if (aluOp == ALUOP_DIV) begin
            if (b == '0) begin
              state_d = MD_DONE;
              hi_d    = a;
              lo_d    = '1;
              done_d  = 1'b1;
              dbz_d   = 1'b1;
            end else begin
              state_d = MD_DIV;
              work_d  = {{WIDTH{1'b0}}, a};
              opnd_d  = b;
            end
          end else if (aluOp == ALUOP_MULT) begin
            state_d = MD_MUL;
            work_d  = {{WIDTH{1'b0}}, b};
            opnd_d  = a;
          end
        end
      end
      MD_MUL, MD_DIV: begin
        if (flush) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          work_d = step_out;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_d = MD_DONE;
            cnt_d   = '0;
            hi_d    = step_out[2*WIDTH-1:WIDTH];
            lo_d    = step_out[WIDTH-1:0];
            done_d  = 1'b1;
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
    busy_d = (state_d != MD_IDLE);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Self-checking bench for muldiv_sequencer: directed cases plus
//                randomized MULT/DIV/flush traffic against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   alu_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .aluOp       (alu_op),
    .a           (a),
    .b           (b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("hi", hi, e.hi);
          check("lo", lo, e.lo);
          check("div_by_zero", div_by_zero, e.dbz);
        end
      end else if (div_by_zero === 1'b1) begin
        check("dbz_without_done", 64'd1, 64'd0);
      end
    end
  end

  // Issue one request; flush_at > 0 aborts that many cycles after acceptance
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input int flush_at);
    int          cyc;
    bit          valid;
    bit          is_dbz;
    exp_t        e;
    logic [63:0] p;
    @(negedge clk);
    start  = 1'b1;
    alu_op = op;
    a      = av;
    b      = bv;
    @(negedge clk);
    start  = 1'b0;
    alu_op = 3'($urandom_range(0, 7));
    a      = $urandom;
    b      = $urandom;
    valid  = (op == ALUOP_MULT) || (op == ALUOP_DIV);
    is_dbz = (op == ALUOP_DIV) && (bv == '0);
    if (!valid) begin
      check("ignored_busy", busy, 0);
      repeat (3) @(negedge clk);
      check("ignored_hi", hi, m_hi);
      check("ignored_lo", lo, m_lo);
      return;
    end
    if (flush_at > 0 && !is_dbz) begin
      repeat (flush_at - 1) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy", busy, 0);
      repeat (W + 4) @(negedge clk);
      check("flush_hi", hi, m_hi);
      check("flush_lo", lo, m_lo);
      return;
    end
    if (op == ALUOP_MULT) begin
      p     = 64'(av) * 64'(bv);
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.dbz = 1'b0;
    end else if (is_dbz) begin
      e.hi  = av;
      e.lo  = '1;
      e.dbz = 1'b1;
    end else begin
      e.hi  = av % bv;
      e.lo  = av / bv;
      e.dbz = 1'b0;
    end
    sb.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;
    if (!is_dbz) check("busy_running", busy, 1);
    cyc = 1;
    while (done !== 1'b1 && cyc < W + 10) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      check("done_timeout", 64'd0, 64'd1);
    end else if (is_dbz) begin
      check("dbz_latency_le2", 64'(cyc <= 2), 64'd1);
    end else begin
      check("latency", 64'(cyc), 64'(W + 1));
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Main stimulus
  initial begin
    logic [2:0] others [6];
    int         r;
    others = '{ALUOP_AND, ALUOP_OR, ALUOP_ADD, ALUOP_SUB, ALUOP_SLT, ALUOP_NOP};
    rst    = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    alu_op = '0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b0;

    run_op(ALUOP_MULT, 32'd7, 32'd6, 0);
    run_op(ALUOP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(ALUOP_DIV, 32'd100, 32'd7, 0);
    run_op(ALUOP_DIV, 32'd5, 32'd0, 0);
    run_op(ALUOP_ADD, 32'd3, 32'd3, 0);
    run_op(ALUOP_NOP, 32'd3, 32'd3, 0);
    run_op(ALUOP_MULT, 32'd3, 32'd4, 0);
    run_op(ALUOP_MULT, 32'd9, 32'd9, 10);

    // flush and start together in IDLE: nothing accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; alu_op = ALUOP_MULT; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", busy, 0);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; alu_op = ALUOP_DIV; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    run_op(ALUOP_DIV, 32'd9, 32'd2, 0);

    // Randomized traffic
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      run_op(ALUOP_MULT, $urandom, (r == 0) ? 32'($urandom_range(0, 255)) : $urandom, 0);
      else if (r <= 6) run_op(ALUOP_DIV, $urandom, (r == 4) ? 32'($urandom_range(1, 300)) : $urandom, 0);
      else if (r == 7) run_op(ALUOP_DIV, $urandom, 32'd0, 0);
      else if (r == 8) run_op(others[$urandom_range(0, 5)], $urandom, $urandom, 0);
      else             run_op(($urandom_range(0, 1) != 0) ? ALUOP_MULT : ALUOP_DIV,
                              $urandom, $urandom | 32'd1, int'($urandom_range(1, W - 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
